otter_pl_hazard_ctrl: RTL and testbench
=======================================

Name: otter_pl_hazard_ctrl

Overview:
- Pipeline sequencer for the 5-stage OTTER (IF/ID/EX/MEM/WB) built around the no-hazard pipelined decoder.
- Detects load-use hazards and stalls the front end for one cycle. Flushes wrong-path instructions on an EX-stage redirect.
- Sequences interrupt entry: drain the back end, then assert INT_TAKEN to the decoder so PCSOURCE selects the interrupt vector.
- Keeps saturating stall/flush performance counters.

Parameters:
- DRAIN_CYCLES, 3, number of bubble cycles inserted before interrupt take; covers the EX, MEM and WB occupancy.
- CNT_W, 16, width of each performance counter.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- ID_VALID  in  1  ID stage holds a real (non-bubble) instruction.
- ID_PC  in  32  PC of the instruction in ID.
- ID_RS1, ID_RS2  in  5 each  source registers of the ID instruction.
- ID_USES_RS1, ID_USES_RS2  in  1 each  ID instruction reads rs1/rs2.
- EX_RD  in  5  destination register of the EX instruction.
- EX_MEM_READ  in  1  EX instruction is a load (MEM_READ_2 piped to EX).
- EX_REDIRECT  in  1  EX resolved a PC change: taken branch, jal, jalr or mret.
- INTR  in  1  external interrupt request, level-sensitive.
- MIE  in  1  interrupt enable from the CSR file.
- CNT_CLR  in  1  synchronous clear of both counters.
- PC_WRITE  out  1  PC register enable.
- IF_ID_WRITE  out  1  IF/ID register enable.
- IF_ID_FLUSH  out  1  load a bubble into IF/ID.
- ID_EX_BUBBLE  out  1  load a bubble into ID/EX (all write/enable controls zero).
- INT_TAKEN  out  1  drives intTaken on the decoder; PCSOURCE becomes 3'b100.
- EPC  out  32  registered PC saved for mepc.
- STALL_CNT  out  CNT_W  count of load-use stall cycles.
- FLUSH_CNT  out  CNT_W  count of redirect flush events.

Behaviour:
- State machine with states RUN, INT_DRAIN and INT_TAKE, plus a drain counter.
- Reset (asynchronous):
  - state = RUN; drain counter, EPC, STALL_CNT and FLUSH_CNT = 0.
  - While RST is high the combinational outputs are forced: PC_WRITE=0, IF_ID_WRITE=0, IF_ID_FLUSH=1, ID_EX_BUBBLE=1, INT_TAKEN=0.
- Default outputs in RUN: PC_WRITE=1, IF_ID_WRITE=1, IF_ID_FLUSH=0, ID_EX_BUBBLE=0, INT_TAKEN=0. All outputs are combinational, zero latency.
- Load-use hazard (lu) is true when all of the following hold:
  - ID_VALID, EX_MEM_READ and EX_RD != 0;
  - (ID_USES_RS1 and ID_RS1 == EX_RD) or (ID_USES_RS2 and ID_RS2 == EX_RD).
- RUN priority, highest first:
  - EX_REDIRECT: IF_ID_FLUSH=1 and ID_EX_BUBBLE=1; PC_WRITE=1 so the redirect target loads. lu is ignored. FLUSH_CNT increments. Interrupt entry is deferred.
  - INTR and MIE and ID_VALID: capture EPC <= ID_PC, load drain counter with DRAIN_CYCLES-1, go to INT_DRAIN. The ID instruction is squashed in this cycle (ID_EX_BUBBLE=1, PC_WRITE=0, IF_ID_WRITE=0).
  - lu: PC_WRITE=0, IF_ID_WRITE=0, ID_EX_BUBBLE=1 for exactly one cycle (MEM/WB forwarding handles the rest). STALL_CNT increments.
  - INTR with ID_VALID=0 (bubble in ID) waits in RUN until ID_VALID=1.
- INT_DRAIN:
  - Outputs: PC_WRITE=0, IF_ID_WRITE=0, ID_EX_BUBBLE=1.
  - Decrement the counter each cycle; move to INT_TAKE when it reaches 0.
  - Total cycles spent in INT_DRAIN = DRAIN_CYCLES.
  - INTR, MIE and EX_REDIRECT are ignored (EX holds only bubbles).
  - Entry is committed: INTR dropping does not abort the drain.
- INT_TAKE (exactly 1 cycle):
  - Outputs: INT_TAKEN=1, PC_WRITE=1, IF_ID_FLUSH=1, ID_EX_BUBBLE=1.
  - Next state is RUN. The CSR file clears MIE on INT_TAKEN, so no immediate re-entry occurs.
- Counters:
  - Saturate at all-ones with no wrap.
  - CNT_CLR has priority over an increment in the same cycle.
- RST mid-drain returns immediately to RUN; EPC is cleared.

Decomposition:
- Package otter_pl_pkg holds:
  - hz_state_t enum {RUN, INT_DRAIN, INT_TAKE};
  - PCSOURCE constants (PC_SRC_NEXT=3'b000, PC_SRC_JALR=3'b001, PC_SRC_BR=3'b010, PC_SRC_JAL=3'b011, PC_SRC_INTR=3'b100, PC_SRC_MRET=3'b101);
  - a bubble-control constant for ID/EX.
- One sub-module, otter_sat_counter, parameterised by width, with inc and clr inputs. It is instantiated twice (STALL_CNT, FLUSH_CNT).

Test Plan:
- Load x5 then `add x6,x5,x1` back-to-back -> one cycle with PC_WRITE=0, IF_ID_WRITE=0, ID_EX_BUBBLE=1; next cycle all defaults; STALL_CNT=1.
- Load x0 then a consumer of x0, and separately a load x5 followed by an instruction with ID_USES_RS2=0 and ID_RS2=5 -> no stall in either case; STALL_CNT unchanged.
- EX_REDIRECT coincident with lu -> IF_ID_FLUSH=1, ID_EX_BUBBLE=1, PC_WRITE=1; STALL_CNT unchanged; FLUSH_CNT +1.
- INTR=1, MIE=1, ID_PC=0x0000_0040 -> EPC=0x40; 3 INT_DRAIN cycles with PC_WRITE=0; then 1 cycle with INT_TAKEN=1, PC_WRITE=1; then RUN. INTR dropped after cycle 1 gives the identical sequence.
- INTR and EX_REDIRECT in the same cycle, followed by a cycle with ID_VALID=0 -> no entry until the first cycle with ID_VALID=1; EPC = the redirect target PC.
- RST asserted during the 2nd drain cycle -> state RUN and EPC=0. Separately, with CNT_W=4, 17 stalls -> STALL_CNT=15; CNT_CLR together with a stall -> 0.

Source files
------------

// File: rtl/otter_pl_pkg.sv
// Shared types and constants for the OTTER pipeline hazard sequencer.
package otter_pl_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        INT_DRAIN = 2'd1,
        INT_TAKE  = 2'd2
    } hz_state_t;

    localparam logic [2:0] PC_SRC_NEXT = 3'b000;
    localparam logic [2:0] PC_SRC_JALR = 3'b001;
    localparam logic [2:0] PC_SRC_BR   = 3'b010;
    localparam logic [2:0] PC_SRC_JAL  = 3'b011;
    localparam logic [2:0] PC_SRC_INTR = 3'b100;
    localparam logic [2:0] PC_SRC_MRET = 3'b101;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_bubble;
        logic int_taken;
    } hz_ctrl_t;

    // Normal flow: everything advances, nothing squashed.
    localparam hz_ctrl_t CTRL_RUN    = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                                         id_ex_bubble: 1'b0, int_taken: 1'b0};
    // Front end frozen while a bubble enters ID/EX.
    localparam hz_ctrl_t CTRL_BUBBLE = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                         id_ex_bubble: 1'b1, int_taken: 1'b0};
    localparam hz_ctrl_t CTRL_FLUSH  = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
                                         id_ex_bubble: 1'b1, int_taken: 1'b0};
    localparam hz_ctrl_t CTRL_TAKE   = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
                                         id_ex_bubble: 1'b1, int_taken: 1'b1};
    localparam hz_ctrl_t CTRL_RESET  = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b1,
                                         id_ex_bubble: 1'b1, int_taken: 1'b0};

endpackage

// File: rtl/otter_sat_counter.sv
// Saturating event counter; clear wins over increment.
module otter_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/otter_pl_hazard_ctrl.sv
// OTTER 5-stage pipeline sequencer: load-use stall, redirect flush,
// interrupt drain/take, and stall/flush performance counters.
module otter_pl_hazard_ctrl
    import otter_pl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ID_VALID,
    input  logic [31:0]      ID_PC,
    input  logic [4:0]       ID_RS1,
    input  logic [4:0]       ID_RS2,
    input  logic             ID_USES_RS1,
    input  logic             ID_USES_RS2,
    input  logic [4:0]       EX_RD,
    input  logic             EX_MEM_READ,
    input  logic             EX_REDIRECT,
    input  logic             INTR,
    input  logic             MIE,
    input  logic             CNT_CLR,
    output logic             PC_WRITE,
    output logic             IF_ID_WRITE,
    output logic             IF_ID_FLUSH,
    output logic             ID_EX_BUBBLE,
    output logic             INT_TAKEN,
    output logic [31:0]      EPC,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [CNT_W-1:0] FLUSH_CNT
);

    localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRN_W-1:0] DRAIN_LOAD = DRN_W'(DRAIN_CYCLES - 1);

    hz_state_t        state, state_next;
    logic [DRN_W-1:0] drain_cnt, drain_next;
    hz_ctrl_t         ctrl;
    logic             load_use;
    logic             epc_capture;
    logic             stall_inc;
    logic             flush_inc;

    assign load_use = ID_VALID && EX_MEM_READ && (EX_RD != 5'd0) &&
                      ((ID_USES_RS1 && (ID_RS1 == EX_RD)) ||
                       (ID_USES_RS2 && (ID_RS2 == EX_RD)));

    always_comb begin
        ctrl        = CTRL_RUN;
        state_next  = state;
        drain_next  = drain_cnt;
        epc_capture = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;

        case (state)
            RUN: begin
                // Redirect outranks everything: the ID instruction is wrong-path,
                // so neither a stall nor an interrupt entry may be based on it.
                if (EX_REDIRECT) begin
                    ctrl      = CTRL_FLUSH;
                    flush_inc = 1'b1;
                end else if (INTR && MIE && ID_VALID) begin
                    ctrl        = CTRL_BUBBLE;
                    epc_capture = 1'b1;
                    drain_next  = DRAIN_LOAD;
                    state_next  = INT_DRAIN;
                end else if (load_use) begin
                    ctrl      = CTRL_BUBBLE;
                    stall_inc = 1'b1;
                end
            end
            INT_DRAIN: begin
                ctrl = CTRL_BUBBLE;
                if (drain_cnt == '0) begin
                    state_next = INT_TAKE;
                end else begin
                    drain_next = drain_cnt - DRN_W'(1);
                end
            end
            INT_TAKE: begin
                ctrl       = CTRL_TAKE;
                state_next = RUN;
            end
            default: begin
                state_next = RUN;
            end
        endcase

        if (RST) begin
            ctrl = CTRL_RESET;
        end
    end

    assign PC_WRITE     = ctrl.pc_write;
    assign IF_ID_WRITE  = ctrl.if_id_write;
    assign IF_ID_FLUSH  = ctrl.if_id_flush;
    assign ID_EX_BUBBLE = ctrl.id_ex_bubble;
    assign INT_TAKEN    = ctrl.int_taken;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= RUN;
            drain_cnt <= '0;
            EPC       <= 32'd0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_next;
            if (epc_capture) begin
                EPC <= ID_PC;
            end
        end
    end

    otter_sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (CLK),
        .rst   (RST),
        .inc   (stall_inc),
        .clr   (CNT_CLR),
        .count (STALL_CNT)
    );

    otter_sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (CLK),
        .rst   (RST),
        .inc   (flush_inc),
        .clr   (CNT_CLR),
        .count (FLUSH_CNT)
    );

endmodule

// File: tb/tb_otter_pl_hazard_ctrl.sv
// Directed bench for otter_pl_hazard_ctrl (DRAIN_CYCLES=3, CNT_W=4).
module tb_otter_pl_hazard_ctrl;

    localparam int CW = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic          ID_VALID;
    logic [31:0]   ID_PC;
    logic [4:0]    ID_RS1, ID_RS2;
    logic          ID_USES_RS1, ID_USES_RS2;
    logic [4:0]    EX_RD;
    logic          EX_MEM_READ, EX_REDIRECT, INTR, MIE, CNT_CLR;
    logic          PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_BUBBLE, INT_TAKEN;
    logic [31:0]   EPC;
    logic [CW-1:0] STALL_CNT, FLUSH_CNT;

    int errors = 0;
    int checks = 0;

    otter_pl_hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST), .ID_VALID(ID_VALID), .ID_PC(ID_PC),
        .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_USES_RS1(ID_USES_RS1), .ID_USES_RS2(ID_USES_RS2),
        .EX_RD(EX_RD), .EX_MEM_READ(EX_MEM_READ), .EX_REDIRECT(EX_REDIRECT),
        .INTR(INTR), .MIE(MIE), .CNT_CLR(CNT_CLR),
        .PC_WRITE(PC_WRITE), .IF_ID_WRITE(IF_ID_WRITE), .IF_ID_FLUSH(IF_ID_FLUSH),
        .ID_EX_BUBBLE(ID_EX_BUBBLE), .INT_TAKEN(INT_TAKEN), .EPC(EPC),
        .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_in();
        ID_VALID = 0; ID_PC = 0; ID_RS1 = 0; ID_RS2 = 0;
        ID_USES_RS1 = 0; ID_USES_RS2 = 0; EX_RD = 0;
        EX_MEM_READ = 0; EX_REDIRECT = 0; INTR = 0; MIE = 0; CNT_CLR = 0;
    endtask

    task automatic set_load_use();
        ID_VALID = 1; ID_RS1 = 5; ID_USES_RS1 = 1; ID_RS2 = 1; ID_USES_RS2 = 1;
        EX_RD = 5; EX_MEM_READ = 1;
    endtask

    task automatic chk_front(input string tag, input logic pcw, input logic ifw,
                             input logic fl, input logic bub, input logic it);
        chk({tag, ".pc_write"},     32'(PC_WRITE),     32'(pcw));
        chk({tag, ".if_id_write"},  32'(IF_ID_WRITE),  32'(ifw));
        chk({tag, ".if_id_flush"},  32'(IF_ID_FLUSH),  32'(fl));
        chk({tag, ".id_ex_bubble"}, 32'(ID_EX_BUBBLE), 32'(bub));
        chk({tag, ".int_taken"},    32'(INT_TAKEN),    32'(it));
    endtask

    initial begin
        clear_in();
        RST = 1;
        #3;
        chk_front("reset", 0, 0, 1, 1, 0);
        chk("reset.epc", EPC, 32'h0);
        chk("reset.stall_cnt", 32'(STALL_CNT), 32'd0);
        chk("reset.flush_cnt", 32'(FLUSH_CNT), 32'd0);
        @(negedge CLK);
        RST = 0;
        #1;
        chk_front("idle", 1, 1, 0, 0, 0);

        // load x5; add x6,x5,x1
        tick();
        set_load_use();
        #1;
        chk_front("lu", 0, 0, 0, 1, 0);
        tick();
        chk("lu.stall_cnt", 32'(STALL_CNT), 32'd1);
        EX_MEM_READ = 0; EX_RD = 6;
        #1;
        chk_front("lu_after", 1, 1, 0, 0, 0);

        // load x0 feeding x0: no stall
        tick();
        clear_in();
        ID_VALID = 1; ID_RS1 = 0; ID_USES_RS1 = 1; EX_RD = 0; EX_MEM_READ = 1;
        #1;
        chk_front("lu_x0", 1, 1, 0, 0, 0);
        tick();
        // rs2 matches but is unused: no stall
        clear_in();
        ID_VALID = 1; ID_RS1 = 1; ID_USES_RS1 = 1; ID_RS2 = 5; ID_USES_RS2 = 0;
        EX_RD = 5; EX_MEM_READ = 1;
        #1;
        chk_front("lu_rs2_unused", 1, 1, 0, 0, 0);
        tick();
        chk("no_stall.stall_cnt", 32'(STALL_CNT), 32'd1);

        // redirect coincident with a load-use
        clear_in();
        set_load_use();
        EX_REDIRECT = 1;
        #1;
        chk_front("redir_lu", 1, 1, 1, 1, 0);
        tick();
        chk("redir_lu.stall_cnt", 32'(STALL_CNT), 32'd1);
        chk("redir_lu.flush_cnt", 32'(FLUSH_CNT), 32'd1);

        // interrupt entry; second pass drops INTR and raises EX_REDIRECT during the drain
        for (int r = 0; r < 2; r++) begin
            clear_in();
            ID_VALID = 1; ID_PC = (r == 0) ? 32'h40 : 32'h44; INTR = 1; MIE = 1;
            #1;
            chk_front("int_entry", 0, 0, 0, 1, 0);
            tick();
            chk("int_entry.epc", EPC, (r == 0) ? 32'h40 : 32'h44);
            if (r == 1) begin
                INTR = 0; EX_REDIRECT = 1;
            end
            for (int d = 0; d < 3; d++) begin
                #1;
                chk_front("int_drain", 0, 0, 0, 1, 0);
                tick();
            end
            EX_REDIRECT = 0;
            #1;
            chk("int_take.int_taken", 32'(INT_TAKEN), 32'd1);
            chk("int_take.pc_write", 32'(PC_WRITE), 32'd1);
            chk("int_take.if_id_flush", 32'(IF_ID_FLUSH), 32'd1);
            chk("int_take.id_ex_bubble", 32'(ID_EX_BUBBLE), 32'd1);
            MIE = 0;
            tick();
            chk_front("int_after", 1, 1, 0, 0, 0);
        end
        chk("int.flush_cnt", 32'(FLUSH_CNT), 32'd1);
        chk("int.stall_cnt", 32'(STALL_CNT), 32'd1);

        // interrupt deferred by a redirect, then a bubble in ID
        tick();
        clear_in();
        ID_VALID = 1; ID_PC = 32'h100; INTR = 1; MIE = 1; EX_REDIRECT = 1;
        #1;
        chk_front("int_redir", 1, 1, 1, 1, 0);
        tick();
        chk("int_redir.flush_cnt", 32'(FLUSH_CNT), 32'd2);
        chk("int_redir.epc", EPC, 32'h44);
        ID_VALID = 0; EX_REDIRECT = 0;
        #1;
        chk_front("int_bubble_wait", 1, 1, 0, 0, 0);
        tick();
        chk("int_bubble_wait.epc", EPC, 32'h44);
        ID_VALID = 1; ID_PC = 32'h200;
        #1;
        chk_front("int_late_entry", 0, 0, 0, 1, 0);
        tick();
        chk("int_late_entry.epc", EPC, 32'h200);
        INTR = 0;
        #1;
        chk("drain1.pc_write", 32'(PC_WRITE), 32'd0);
        tick();
        #1;
        chk("drain2.pc_write", 32'(PC_WRITE), 32'd0);
        #1;
        RST = 1;
        #1;
        chk("rst_mid.epc", EPC, 32'h0);
        chk_front("rst_mid", 0, 0, 1, 1, 0);
        chk("rst_mid.flush_cnt", 32'(FLUSH_CNT), 32'd0);
        @(negedge CLK);
        RST = 0;
        MIE = 0;
        #1;
        chk_front("rst_mid_run", 1, 1, 0, 0, 0);
        tick();
        chk_front("rst_mid_run2", 1, 1, 0, 0, 0);

        // saturation with CNT_W=4: 17 stalls stop at 15
        clear_in();
        set_load_use();
        repeat (17) tick();
        chk("sat.stall_cnt", 32'(STALL_CNT), 32'd15);
        EX_REDIRECT = 1;
        tick();
        chk("sat_redir.flush_cnt", 32'(FLUSH_CNT), 32'd1);
        chk("sat_redir.stall_cnt", 32'(STALL_CNT), 32'd15);
        EX_REDIRECT = 0;
        CNT_CLR = 1;
        #1;
        chk("clr.lu_bubble", 32'(ID_EX_BUBBLE), 32'd1);
        tick();
        chk("clr.stall_cnt", 32'(STALL_CNT), 32'd0);
        chk("clr.flush_cnt", 32'(FLUSH_CNT), 32'd0);
        CNT_CLR = 0;
        tick();
        chk("post_clr.stall_cnt", 32'(STALL_CNT), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
